// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: IICMB register map, command opcodes, response bits and sequencer state types.
package i2c_seq_pkg;

    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;
    localparam logic [1:0] ADR_FSMR = 2'd3;

    localparam logic [7:0] CMD_SET_BUS  = 8'h06;
    localparam logic [7:0] CMD_START    = 8'h04;
    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ_ACK = 8'h02;
    localparam logic [7:0] CMD_READ_NAK = 8'h03;
    localparam logic [7:0] CMD_STOP     = 8'h05;

    localparam int RSP_DON = 7;
    localparam int RSP_NAK = 6;
    localparam int RSP_AL  = 5;
    localparam int RSP_ERR = 4;

    localparam logic [7:0] CSR_DISABLE   = 8'h00;
    localparam logic [7:0] CSR_ENABLE_IE = 8'hC0;

    typedef enum logic [3:0] {
        CFG_OFF, CFG_ON, IDLE, SET_BUS, START, ADDR, WDATA, RDATA, RD_DPR, STOP, DONE
    } state_t;

    // Sub-steps of one command: optional DPR write, CMDR write, IRQ wait, response read.
    typedef enum logic [2:0] {
        PH_DPR, PH_DPR_W, PH_CMD, PH_CMD_W, PH_IRQ, PH_RSP, PH_RSP_W
    } phase_t;

    typedef enum logic [1:0] {
        ST_OK = 2'b00, ST_NAK = 2'b01, ST_AL = 2'b10, ST_ERR = 2'b11
    } status_t;

endpackage

// File: rtl/wb_master_port.sv
// wb_master_port: single-transaction Wishbone master; holds registered cycle signals until ack.
module wb_master_port (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       we_i,
    input  logic [1:0] adr_i,
    input  logic [7:0] wdata_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       cyc_o,
    output logic       stb_o,
    output logic       we_o,
    output logic [1:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    input  logic       ack_i
);

    logic       cyc_q, cyc_d;
    logic       we_q, we_d;
    logic [1:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d;

    always_comb begin
        cyc_d = cyc_q;
        we_d  = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        if (cyc_q && ack_i) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            adr_d = 2'd0;
            dat_d = 8'h00;
        end else if (!cyc_q && start_i) begin
            cyc_d = 1'b1;
            we_d  = we_i;
            adr_d = adr_i;
            dat_d = we_i ? wdata_i : 8'h00;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= 2'd0;
            dat_q <= 8'h00;
        end else begin
            cyc_q <= cyc_d;
            we_q  <= we_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
        end
    end

    // Completion is the ack cycle itself so the caller samples read data on the ack edge.
    assign done_o  = cyc_q & ack_i;
    assign rdata_o = dat_i;
    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;
    assign we_o    = we_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: turns one transfer request into the IICMB command sequence
// (Set Bus, Start, address, data, Stop) and reports read bytes and final status.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [1:0]       adr_o,
    output logic [7:0]       dat_o,
    input  logic [7:0]       dat_i,
    input  logic             ack_i,
    input  logic             irq_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_rnw_i,
    input  logic [6:0]       req_addr_i,
    input  logic [3:0]       req_bus_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [7:0]       wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic             busy_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    status_t          status_q, status_d;
    logic             rnw_q, rnw_d;
    logic [6:0]       addr_q, addr_d;
    logic [3:0]       bus_q, bus_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit_q, tmo_hit_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             req_ready_q, req_ready_d;
    logic             wr_ready_q, wr_ready_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic       wb_start, wb_we, wb_done;
    logic [1:0] wb_adr;
    logic [7:0] wb_wdata, wb_rdata, dpr_val, cmd_val;

    wb_master_port u_wb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (wb_start),
        .we_i    (wb_we),
        .adr_i   (wb_adr),
        .wdata_i (wb_wdata),
        .done_o  (wb_done),
        .rdata_o (wb_rdata),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i)
    );

    always_comb begin
        dpr_val  = state_q == SET_BUS ? {4'h0, bus_q} : state_q == ADDR ? {addr_q, rnw_q} : wr_data_i;
        cmd_val  = state_q == CFG_OFF ? CSR_DISABLE :
                   state_q == CFG_ON  ? CSR_ENABLE_IE :
                   state_q == SET_BUS ? CMD_SET_BUS :
                   state_q == START   ? CMD_START :
                   state_q == STOP    ? CMD_STOP :
                   state_q == RDATA   ? (cnt_q == ONE ? CMD_READ_NAK : CMD_READ_ACK) : CMD_WRITE;
        wb_we    = phase_q != PH_RSP;
        wb_adr   = phase_q == PH_DPR ? ADR_DPR :
                   (state_q == CFG_OFF || state_q == CFG_ON) ? ADR_CSR :
                   state_q == RD_DPR ? ADR_DPR : ADR_CMDR;
        wb_wdata = phase_q == PH_DPR ? dpr_val : cmd_val;
        wb_start = state_q != IDLE && state_q != DONE &&
                   (phase_q == PH_DPR ? (state_q != WDATA || (wr_valid_i && wr_ready_q)) :
                    (phase_q == PH_CMD || phase_q == PH_RSP));
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        status_d   = status_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        bus_d      = bus_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        tmo_hit_d  = tmo_hit_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (state_q == IDLE) begin
            if (req_valid_i && req_ready_q) begin
                rnw_d    = req_rnw_i;
                addr_d   = req_addr_i;
                bus_d    = req_bus_i;
                cnt_d    = req_len_i;
                status_d = ST_OK;
                state_d  = SET_BUS;
                phase_d  = PH_DPR;
            end
        end else if (state_q == DONE) begin
            state_d   = tmo_hit_q ? CFG_OFF : IDLE;
            phase_d   = PH_CMD;
            tmo_hit_d = 1'b0;
        end else begin
            case (phase_q)
                PH_DPR, PH_CMD, PH_RSP: begin
                    if (wb_start)
                        phase_d = phase_q == PH_DPR ? PH_DPR_W : phase_q == PH_CMD ? PH_CMD_W : PH_RSP_W;
                end
                PH_DPR_W: if (wb_done) phase_d = PH_CMD;
                PH_CMD_W: begin
                    if (wb_done) begin
                        state_d = state_q == CFG_OFF ? CFG_ON : state_q == CFG_ON ? IDLE : state_q;
                        phase_d = state_q == CFG_OFF ? PH_CMD : PH_IRQ;
                        tmo_d   = '0;
                    end
                end
                PH_IRQ: begin
                    if (irq_i) begin
                        phase_d = PH_RSP;
                    end else if (tmo_q == TMO_MAX) begin
                        state_d   = DONE;
                        status_d  = ST_ERR;
                        tmo_hit_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                PH_RSP_W: begin
                    if (!wb_done) begin
                    end else if (state_q == RD_DPR) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = wb_rdata;
                        cnt_d      = cnt_q - ONE;
                        state_d    = cnt_q == ONE ? STOP : RDATA;
                        phase_d    = PH_CMD;
                    end else if (state_q == STOP) begin
                        state_d  = DONE;
                        status_d = wb_rdata[RSP_ERR] ? ST_ERR : wb_rdata[RSP_AL] ? ST_AL : status_q;
                    end else if (wb_rdata[RSP_ERR]) begin
                        state_d  = STOP;
                        phase_d  = PH_CMD;
                        status_d = ST_ERR;
                    end else if (wb_rdata[RSP_AL]) begin
                        state_d  = DONE;
                        status_d = ST_AL;
                    end else if (wb_rdata[RSP_NAK]) begin
                        state_d  = STOP;
                        phase_d  = PH_CMD;
                        status_d = ST_NAK;
                    end else begin
                        case (state_q)
                            SET_BUS: begin
                                state_d = START;
                                phase_d = PH_CMD;
                            end
                            START: begin
                                state_d = ADDR;
                                phase_d = PH_DPR;
                            end
                            ADDR: begin
                                state_d = cnt_q == '0 ? STOP : rnw_q ? RDATA : WDATA;
                                phase_d = (cnt_q != '0 && !rnw_q) ? PH_DPR : PH_CMD;
                            end
                            WDATA: begin
                                cnt_d   = cnt_q - ONE;
                                state_d = cnt_q == ONE ? STOP : WDATA;
                                phase_d = cnt_q == ONE ? PH_CMD : PH_DPR;
                            end
                            default: begin
                                state_d = RD_DPR;
                                phase_d = PH_RSP;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
        req_ready_d = state_d == IDLE;
        wr_ready_d  = state_d == WDATA && phase_d == PH_DPR;
        done_d      = state_d == DONE;
        busy_d      = state_d != IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= CFG_OFF;
            phase_q     <= PH_CMD;
            status_q    <= ST_OK;
            rnw_q       <= 1'b0;
            addr_q      <= 7'd0;
            bus_q       <= 4'd0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            tmo_hit_q   <= 1'b0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            status_q    <= status_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            bus_q       <= bus_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            tmo_hit_q   <= tmo_hit_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign wr_ready_o  = wr_ready_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign done_o      = done_q;
    assign status_o    = status_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: directed bench with a behavioural IICMB slave that logs register writes.
module tb_i2c_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cyc, stb, we, ack, irq;
    logic [1:0] adr;
    logic [7:0] dat_o, dat_i;
    logic       req_valid, req_ready, req_rnw;
    logic [6:0] req_addr;
    logic [3:0] req_bus, req_len;
    logic [7:0] wr_data, rd_data;
    logic       wr_valid, wr_ready, rd_valid, done, busy;
    logic [1:0] status;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [1:0] last_status = 2'b00;

    logic [7:0] cmd_log[$], dpr_log[$], csr_log[$], rd_log[$], rd_q[$], exp_q[$];
    logic [7:0] nak_op = 8'hFF, al_op = 8'hFF, last_op = 8'h00;
    logic       stall = 1'b0, irq_hold = 1'b0;
    int         irq_cnt = 0;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(.LEN_W(4), .TIMEOUT_CYCLES(100)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .cyc_o       (cyc),
        .stb_o       (stb),
        .we_o        (we),
        .adr_o       (adr),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .ack_i       (ack),
        .irq_i       (irq),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_rnw_i   (req_rnw),
        .req_addr_i  (req_addr),
        .req_bus_i   (req_bus),
        .req_len_i   (req_len),
        .wr_data_i   (wr_data),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .done_o      (done),
        .status_o    (status),
        .busy_o      (busy)
    );

    function automatic logic [7:0] rsp_for(input logic [7:0] op);
        return op == al_op ? 8'hA0 : op == nak_op ? 8'hC0 : 8'h80;
    endfunction

    // IICMB slave: one-cycle ack, IRQ three cycles after each CMDR write, cleared by CMDR read.
    initial begin
        ack = 1'b0;
        irq = 1'b0;
        dat_i = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (ack) begin
                ack = 1'b0;
            end else if (cyc && stb && !stall) begin
                ack = 1'b1;
                if (we) begin
                    case (adr)
                        2'd0: begin csr_log.push_back(dat_o); irq = 1'b0; irq_cnt = 0; end
                        2'd1: dpr_log.push_back(dat_o);
                        2'd2: begin cmd_log.push_back(dat_o); last_op = dat_o; irq_cnt = 3; end
                        default: ;
                    endcase
                end else if (adr == 2'd2) begin
                    dat_i = rsp_for(last_op);
                    irq = 1'b0;
                end else if (adr == 2'd1) begin
                    dat_i = rd_q.size() > 0 ? rd_q.pop_front() : 8'hEE;
                end else begin
                    dat_i = 8'h00;
                end
            end
            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0 && !irq_hold) irq = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) rd_log.push_back(rd_data);
            if (done) begin
                done_cnt++;
                last_status = status;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {4'h0, cyc, stb, we, adr, dat_o, req_ready, wr_ready, rd_valid, done, status, rd_data, busy},
              32'h0000_0001);
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        dpr_log.delete();
        csr_log.delete();
        rd_log.delete();
    endtask

    task automatic cmp_log(input string tag, input int which);
        logic [7:0] got[$];
        case (which)
            0: got = cmd_log;
            1: got = dpr_log;
            2: got = csr_log;
            default: got = rd_log;
        endcase
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, i < got.size() ? {24'h0, got[i]} : 32'hDEAD, {24'h0, exp_q[i]});
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", req_ready, 1);
    endtask

    task automatic send_req(input logic rnw, input logic [6:0] a, input logic [3:0] b, input logic [3:0] l);
        wait_ready();
        req_valid = 1'b1;
        req_rnw = rnw;
        req_addr = a;
        req_bus = b;
        req_len = l;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!wr_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready_wait", wr_ready, 1);
        wr_valid = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        int start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("done_wait", 32'(done_cnt - start), 1);
    endtask

    initial begin
        int cyc_n;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_rnw = 1'b0;
        req_addr = 7'd0;
        req_bus = 4'd0;
        req_len = 4'd0;
        wr_data = 8'h00;
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_outputs");

        rst_n = 1'b1;
        wait_ready();
        check("idle_busy", busy, 0);
        exp_q = {8'h00, 8'hC0};
        cmp_log("init_csr", 2);

        clear_logs();
        send_req(1'b0, 7'h22, 4'h0, 4'd2);
        check("wr_busy", busy, 1);
        push_wr(8'h5A);
        push_wr(8'hA5);
        wait_done(cyc_n);
        check("wr_status", last_status, 2'b00);
        exp_q = {8'h06, 8'h04, 8'h01, 8'h01, 8'h01, 8'h05};
        cmp_log("wr_cmdr", 0);
        exp_q = {8'h00, 8'h44, 8'h5A, 8'hA5};
        cmp_log("wr_dpr", 1);
        exp_q.delete();
        cmp_log("wr_rdlog", 3);

        clear_logs();
        rd_q = {8'h11, 8'h22, 8'h33};
        send_req(1'b1, 7'h22, 4'h3, 4'd3);
        wait_done(cyc_n);
        check("rd_status", last_status, 2'b00);
        exp_q = {8'h06, 8'h04, 8'h01, 8'h02, 8'h02, 8'h03, 8'h05};
        cmp_log("rd_cmdr", 0);
        exp_q = {8'h03, 8'h45};
        cmp_log("rd_dpr", 1);
        exp_q = {8'h11, 8'h22, 8'h33};
        cmp_log("rd_bytes", 3);

        clear_logs();
        nak_op = 8'h01;
        send_req(1'b0, 7'h50, 4'h2, 4'd0);
        wait_done(cyc_n);
        nak_op = 8'hFF;
        check("nak_status", last_status, 2'b01);
        exp_q = {8'h06, 8'h04, 8'h01, 8'h05};
        cmp_log("nak_cmdr", 0);
        exp_q = {8'h02, 8'hA0};
        cmp_log("nak_dpr", 1);
        exp_q.delete();
        cmp_log("nak_rdlog", 3);

        clear_logs();
        al_op = 8'h04;
        send_req(1'b0, 7'h11, 4'h1, 4'd0);
        wait_done(cyc_n);
        al_op = 8'hFF;
        check("al_status", last_status, 2'b10);
        exp_q = {8'h06, 8'h04};
        cmp_log("al_cmdr", 0);

        clear_logs();
        send_req(1'b1, 7'h10, 4'h1, 4'd0);
        wait_done(cyc_n);
        check("after_al_status", last_status, 2'b00);
        exp_q = {8'h06, 8'h04, 8'h01, 8'h05};
        cmp_log("after_al_cmdr", 0);
        exp_q = {8'h01, 8'h21};
        cmp_log("after_al_dpr", 1);

        clear_logs();
        irq_hold = 1'b1;
        send_req(1'b0, 7'h33, 4'h0, 4'd0);
        wait_done(cyc_n);
        check("tmo_status", last_status, 2'b11);
        check("tmo_not_early", cyc_n >= 100, 1);
        check("tmo_not_late", cyc_n <= 130, 1);
        wait_ready();
        irq_hold = 1'b0;
        exp_q = {8'h00, 8'hC0};
        cmp_log("tmo_reinit_csr", 2);
        exp_q = {8'h06};
        cmp_log("tmo_cmdr", 0);

        clear_logs();
        send_req(1'b0, 7'h22, 4'h0, 4'd1);
        begin
            int n = 0;
            @(negedge clk);
            while (!wr_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("rst_wr_ready_wait", wr_ready, 1);
        end
        stall = 1'b1;
        wr_valid = 1'b1;
        wr_data = 8'h77;
        @(negedge clk);
        wr_valid = 1'b0;
        check("cyc_before_rst", cyc, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst_outputs");
        repeat (2) @(negedge clk);
        check_reset_outputs("held_rst_outputs");
        stall = 1'b0;
        clear_logs();
        rst_n = 1'b1;
        wait_ready();
        exp_q = {8'h00, 8'hC0};
        cmp_log("rst_reinit_csr", 2);
        exp_q.delete();
        cmp_log("rst_cmdr", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
